// File: rtl/ysyx_24090012_csr_pkg.sv
// Constants shared by the trap sequencer and the CSR register file:
// machine-mode CSR addresses, mstatus field positions and sequencer states.
package ysyx_24090012_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_T_MEPC,
        S_T_MCAUSE,
        S_T_MSTATUS,
        S_M_MSTATUS,
        S_C_WRITE,
        S_REDIRECT
    } trap_state_e;

    // Only CSRs that physically exist in the register file accept writes.
    function automatic logic csr_writable(input logic [11:0] addr);
        return (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) ||
               (addr == CSR_MEPC)    || (addr == CSR_MCAUSE);
    endfunction

endpackage

// File: rtl/ysyx_24090012_trap_ctrl_if.sv
// Request/accept handshakes from the EXU, CSR file read/write ports and the
// IFU redirect, bundled between the trap sequencer and its neighbours.
interface ysyx_24090012_trap_ctrl_if;
    logic        trap_valid;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic        trap_ready;
    logic        mret_valid;
    logic        mret_ready;
    logic        csr_valid;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_ready;
    logic [31:0] mstatus_i;
    logic [31:0] mtvec_i;
    logic [31:0] mepc_i;
    logic        csr_wen_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;

    modport master (
        output trap_valid, trap_pc, trap_cause, mret_valid, csr_valid,
               csr_addr, csr_wdata, mstatus_i, mtvec_i, mepc_i,
        input  trap_ready, mret_ready, csr_ready, csr_wen_o, csr_waddr_o,
               csr_wdata_o, redirect_valid, redirect_pc, busy
    );

    modport slave (
        input  trap_valid, trap_pc, trap_cause, mret_valid, csr_valid,
               csr_addr, csr_wdata, mstatus_i, mtvec_i, mepc_i,
        output trap_ready, mret_ready, csr_ready, csr_wen_o, csr_waddr_o,
               csr_wdata_o, redirect_valid, redirect_pc, busy
    );
endinterface

// File: rtl/ysyx_24090012_mstatus_xform.sv
// Combinational mstatus update for trap entry (stack MIE into MPIE) and
// mret (restore MIE from MPIE). Both force MPP to machine mode.
module ysyx_24090012_mstatus_xform
    import ysyx_24090012_csr_pkg::*;
(
    input  logic [31:0] mstatus_i,
    input  logic        is_mret_i,
    output logic [31:0] mstatus_o
);

    always_comb begin
        mstatus_o = mstatus_i;
        mstatus_o[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        if (is_mret_i) begin
            mstatus_o[MSTATUS_MIE]  = mstatus_i[MSTATUS_MPIE];
            mstatus_o[MSTATUS_MPIE] = 1'b1;
        end else begin
            mstatus_o[MSTATUS_MPIE] = mstatus_i[MSTATUS_MIE];
            mstatus_o[MSTATUS_MIE]  = 1'b0;
        end
    end

endmodule

// File: rtl/ysyx_24090012_trap_ctrl.sv
// Trap/mret/CSR-write sequencer: serialises the three requesters onto the
// single CSR write port and issues the PC redirect for trap entry and mret.
module ysyx_24090012_trap_ctrl
    import ysyx_24090012_csr_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    ysyx_24090012_trap_ctrl_if.slave      bus
);

    trap_state_e state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cause_q, cause_d;
    logic [11:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        is_mret_q, is_mret_d;

    logic        idle;
    logic [31:0] mstatus_next;
    logic        wen;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        redir;
    logic [31:0] redir_pc;

    ysyx_24090012_mstatus_xform u_xform (
        .mstatus_i (bus.mstatus_i),
        .is_mret_i (is_mret_q),
        .mstatus_o (mstatus_next)
    );

    assign idle           = (state_q == S_IDLE);
    assign bus.trap_ready = idle;
    assign bus.mret_ready = idle & ~bus.trap_valid;
    assign bus.csr_ready  = idle & ~bus.trap_valid & ~bus.mret_valid;
    assign bus.busy       = ~idle;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            cause_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            is_mret_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cause_q   <= cause_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            is_mret_q <= is_mret_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cause_d   = cause_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        is_mret_d = is_mret_q;
        wen       = 1'b0;
        waddr     = '0;
        wdata     = '0;
        redir     = 1'b0;
        redir_pc  = '0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.trap_valid) begin
                    state_d   = S_T_MEPC;
                    pc_d      = bus.trap_pc;
                    cause_d   = bus.trap_cause;
                    is_mret_d = 1'b0;
                end else if (bus.mret_valid) begin
                    state_d   = S_M_MSTATUS;
                    is_mret_d = 1'b1;
                end else if (bus.csr_valid) begin
                    state_d   = S_C_WRITE;
                    addr_d    = bus.csr_addr;
                    wdata_d   = bus.csr_wdata;
                end
            end
            S_T_MEPC: begin
                wen     = 1'b1;
                waddr   = CSR_MEPC;
                wdata   = pc_q;
                state_d = S_T_MCAUSE;
            end
            S_T_MCAUSE: begin
                wen     = 1'b1;
                waddr   = CSR_MCAUSE;
                wdata   = cause_q;
                state_d = S_T_MSTATUS;
            end
            S_T_MSTATUS, S_M_MSTATUS: begin
                wen     = 1'b1;
                waddr   = CSR_MSTATUS;
                wdata   = mstatus_next;
                state_d = S_REDIRECT;
            end
            S_C_WRITE: begin
                // Unknown addresses still spend their cycle here, just without a strobe.
                wen     = csr_writable(addr_q);
                waddr   = addr_q;
                wdata   = wdata_q;
                state_d = S_IDLE;
            end
            S_REDIRECT: begin
                // Direct mode only: the low two bits of the target are dropped.
                redir    = 1'b1;
                redir_pc = (is_mret_q ? bus.mepc_i : bus.mtvec_i) & 32'hFFFF_FFFC;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.csr_wen_o      = wen;
    assign bus.csr_waddr_o    = waddr;
    assign bus.csr_wdata_o    = wdata;
    assign bus.redirect_valid = redir;
    assign bus.redirect_pc    = redir_pc;

endmodule
